// File: rtl/miner_pkg.sv
// Shared types and constants for the SHA-256 miner core control path.
package miner_pkg;

  localparam int NUM_ROUNDS = 64;
  localparam int ROUND_BITS = 7;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    ROUND = 3'd2,
    FINAL = 3'd3,
    CHECK = 3'd4,
    NEXT  = 3'd5,
    DONE  = 3'd6
  } state_t;

endpackage

// File: rtl/flex_counter.sv
// Up-counter with synchronous clear that wraps to zero after rollover_val.
module flex_counter #(
  parameter int NUM_CNT_BITS = 4
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clear,
  input  logic                    count_enable,
  input  logic [NUM_CNT_BITS-1:0] rollover_val,
  output logic [NUM_CNT_BITS-1:0] count_out,
  output logic                    rollover_flag
);

  assign rollover_flag = (count_out == rollover_val);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_out <= '0;
    end else if (clear) begin
      count_out <= '0;
    end else if (count_enable) begin
      count_out <= rollover_flag ? '0 : count_out + NUM_CNT_BITS'(1);
    end
  end

endmodule

// File: rtl/sha_round_sequencer.sv
// Control FSM for one SHA-256 miner core: walks a nonce range and sequences
// load, rounds, finalize and target check for each nonce.
module sha_round_sequencer
  import miner_pkg::*;
#(
  parameter int NUM_ROUNDS = miner_pkg::NUM_ROUNDS,
  parameter int ROUND_BITS = miner_pkg::ROUND_BITS,
  parameter int NONCE_BITS = 32
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [NONCE_BITS-1:0] nonce_start,
  input  logic [NONCE_BITS-1:0] nonce_end,
  input  logic                  hit,
  output logic                  load_msg,
  output logic                  round_en,
  output logic [ROUND_BITS-1:0] round_idx,
  output logic                  finalize,
  output logic                  check_en,
  output logic [NONCE_BITS-1:0] nonce,
  output logic                  busy,
  output logic                  done,
  output logic                  found,
  output logic                  exhausted,
  output state_t                state
);

  logic [NONCE_BITS-1:0] nonce_last;
  logic [ROUND_BITS-1:0] round_cnt;
  logic                  last_round;

  flex_counter #(
    .NUM_CNT_BITS(ROUND_BITS)
  ) u_round_counter (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        ((state == LOAD) | abort),
    .count_enable (state == ROUND),
    .rollover_val (ROUND_BITS'(NUM_ROUNDS - 1)),
    .count_out    (round_cnt),
    .rollover_flag(last_round)
  );

  // Strobes decode from the state register only, so no input reaches an output.
  assign load_msg  = (state == LOAD);
  assign round_en  = (state == ROUND);
  assign round_idx = (state == ROUND) ? round_cnt : '0;
  assign finalize  = (state == FINAL);
  assign check_en  = (state == CHECK);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= IDLE;
      nonce      <= '0;
      nonce_last <= '0;
      found      <= 1'b0;
      exhausted  <= 1'b0;
    end else if (state != IDLE && abort) begin
      // Abort wins over hit and suppresses the done pulse.
      state     <= IDLE;
      found     <= 1'b0;
      exhausted <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state      <= LOAD;
            nonce      <= nonce_start;
            nonce_last <= nonce_end;
            found      <= 1'b0;
            exhausted  <= 1'b0;
          end
        end
        LOAD:  state <= ROUND;
        ROUND: if (last_round) state <= FINAL;
        FINAL: state <= CHECK;
        CHECK: begin
          if (hit) begin
            state <= DONE;
            found <= 1'b1;
          end else if (nonce == nonce_last) begin
            state     <= DONE;
            exhausted <= 1'b1;
          end else begin
            state <= NEXT;
          end
        end
        NEXT: begin
          nonce <= nonce + NONCE_BITS'(1);
          state <= LOAD;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sha_round_sequencer.sv
// Directed bench for sha_round_sequencer with hand-computed cycle counts and nonce sequences.
module tb_sha_round_sequencer;
  import miner_pkg::*;

  logic        clk;
  logic        n_rst;
  logic        start;
  logic        abort;
  logic [31:0] nonce_start;
  logic [31:0] nonce_end;
  logic        hit;
  logic        load_msg;
  logic        round_en;
  logic [6:0]  round_idx;
  logic        finalize;
  logic        check_en;
  logic [31:0] nonce;
  logic        busy;
  logic        done;
  logic        found;
  logic        exhausted;
  state_t      state;

  int checks;
  int errors;

  // monitor counters and observed nonce stream
  int load_cnt;
  int round_cnt;
  int done_cnt;
  int idx_err;
  int exp_idx;
  logic [31:0] obs_q[$];
  logic [31:0] exp_q[$];

  sha_round_sequencer dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .start      (start),
    .abort      (abort),
    .nonce_start(nonce_start),
    .nonce_end  (nonce_end),
    .hit        (hit),
    .load_msg   (load_msg),
    .round_en   (round_en),
    .round_idx  (round_idx),
    .finalize   (finalize),
    .check_en   (check_en),
    .nonce      (nonce),
    .busy       (busy),
    .done       (done),
    .found      (found),
    .exhausted  (exhausted),
    .state      (state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  always @(negedge clk) begin
    if (n_rst) begin
      if (load_msg) begin
        load_cnt++;
        exp_idx = 0;
      end
      if (round_en) begin
        round_cnt++;
        if (round_idx !== 7'(exp_idx)) idx_err++;
        exp_idx++;
      end
      if (check_en) obs_q.push_back(nonce);
      if (done) done_cnt++;
    end
  end

  // driver tasks
  task automatic clear_mon();
    load_cnt  = 0;
    round_cnt = 0;
    done_cnt  = 0;
    idx_err   = 0;
    exp_idx   = 0;
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic start_job(input logic [31:0] ns, input logic [31:0] ne, input logic with_abort);
    @(negedge clk);
    clear_mon();
    nonce_start = ns;
    nonce_end   = ne;
    start       = 1'b1;
    abort       = with_abort;
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int cyc, output bit seen);
    cyc  = 0;
    seen = 1'b0;
    while (cyc < budget && !seen) begin
      @(negedge clk);
      cyc++;
      if (done) seen = 1'b1;
    end
    #1;
  endtask

  task automatic check_stream(input string name);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL %s nonce count: got %0d expected %0d", name, obs_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL %s nonce[%0d]: got %h expected %h", name, i, obs_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_reset();
    int cyc;
    n_rst = 1'b0;
    start = 1'b0; abort = 1'b0; hit = 1'b0;
    nonce_start = '0; nonce_end = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({load_msg, round_en, round_idx, finalize, check_en, nonce, busy, done, found, exhausted} !== 47'h0
        || state !== IDLE) begin
      errors++;
      $display("FAIL reset_values: got outputs nonzero or state %0d, expected all 0 and IDLE", state);
    end
    n_rst = 1'b1;
    start_job(32'd7, 32'd7, 1'b0);
    cyc = 0;
    while (cyc < 200 && !(round_en && round_idx == 7'd10)) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (cyc >= 200) begin
      errors++;
      $display("FAIL reset_reach_round10: got timeout, expected round_idx 10");
    end
    n_rst = 1'b0;
    #1;
    checks++;
    if ({load_msg, round_en, round_idx, finalize, check_en, nonce, busy, done, found, exhausted} !== 47'h0
        || state !== IDLE) begin
      errors++;
      $display("FAIL reset_midjob: got nonce=%h busy=%b state=%0d, expected all 0 and IDLE", nonce, busy, state);
    end
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (done_cnt != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_done: got done_cnt=%0d busy=%b, expected 0 and 0", done_cnt, busy);
    end
  endtask

  task automatic test_single_hit();
    int cyc; bit seen;
    hit = 1'b1;
    start_job(32'd5, 32'd5, 1'b0);
    wait_done(400, cyc, seen);
    exp_q.push_back(32'd5);
    checks++;
    if (!seen || cyc != 68) begin
      errors++;
      $display("FAIL hit_latency: got cycle %0d seen=%b, expected 68", cyc, seen);
    end
    checks++;
    if (found !== 1'b1 || exhausted !== 1'b0 || nonce !== 32'd5) begin
      errors++;
      $display("FAIL hit_flags: got found=%b exh=%b nonce=%h, expected 1 0 5", found, exhausted, nonce);
    end
    checks++;
    if (round_cnt != 64 || idx_err != 0 || load_cnt != 1) begin
      errors++;
      $display("FAIL hit_rounds: got rounds=%0d idx_err=%0d loads=%0d, expected 64 0 1",
               round_cnt, idx_err, load_cnt);
    end
    check_stream("hit");
    hit = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || found !== 1'b1 || nonce !== 32'd5) begin
      errors++;
      $display("FAIL hit_hold: got busy=%b done=%b found=%b nonce=%h, expected 0 0 1 5",
               busy, done, found, nonce);
    end
  endtask

  task automatic test_range();
    int cyc; bit seen;
    start_job(32'd10, 32'd12, 1'b0);
    wait_done(1000, cyc, seen);
    exp_q.push_back(32'd10); exp_q.push_back(32'd11); exp_q.push_back(32'd12);
    checks++;
    if (!seen || cyc != 204) begin
      errors++;
      $display("FAIL range_latency: got cycle %0d seen=%b, expected 204", cyc, seen);
    end
    checks++;
    if (exhausted !== 1'b1 || found !== 1'b0 || nonce !== 32'd12 || load_cnt != 3 || round_cnt != 192) begin
      errors++;
      $display("FAIL range_result: got exh=%b found=%b nonce=%h loads=%0d rounds=%0d, expected 1 0 c 3 192",
               exhausted, found, nonce, load_cnt, round_cnt);
    end
    check_stream("range");
  endtask

  task automatic test_wrap();
    int cyc; bit seen;
    start_job(32'hFFFF_FFFE, 32'h1, 1'b0);
    wait_done(1000, cyc, seen);
    exp_q.push_back(32'hFFFF_FFFE); exp_q.push_back(32'hFFFF_FFFF);
    exp_q.push_back(32'h0);         exp_q.push_back(32'h1);
    checks++;
    if (!seen || cyc != 272) begin
      errors++;
      $display("FAIL wrap_latency: got cycle %0d seen=%b, expected 272", cyc, seen);
    end
    checks++;
    if (exhausted !== 1'b1 || nonce !== 32'h1) begin
      errors++;
      $display("FAIL wrap_result: got exh=%b nonce=%h, expected 1 1", exhausted, nonce);
    end
    check_stream("wrap");
  endtask

  task automatic test_abort();
    int cyc; bit seen;
    start_job(32'd0, 32'd100, 1'b0);
    cyc = 0;
    while (cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if (state !== IDLE || busy !== 1'b0 || done !== 1'b0 || found !== 1'b0 || exhausted !== 1'b0
        || {load_msg, round_en, finalize, check_en} !== 4'b0) begin
      errors++;
      $display("FAIL abort_idle: got state=%0d busy=%b done=%b found=%b exh=%b, expected IDLE 0 0 0 0",
               state, busy, done, found, exhausted);
    end
    checks++;
    if (nonce !== 32'd1) begin
      errors++;
      $display("FAIL abort_nonce_hold: got %h expected 1", nonce);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (done_cnt != 0) begin
      errors++;
      $display("FAIL abort_no_done: got done_cnt=%0d expected 0", done_cnt);
    end
    start_job(32'd3, 32'd3, 1'b0);
    wait_done(400, cyc, seen);
    checks++;
    if (!seen || cyc != 68 || exhausted !== 1'b1 || nonce !== 32'd3) begin
      errors++;
      $display("FAIL abort_restart: got cycle %0d exh=%b nonce=%h, expected 68 1 3", cyc, exhausted, nonce);
    end
  endtask

  task automatic test_busy_ignore();
    int cyc; bit seen;
    start_job(32'd20, 32'd21, 1'b0);
    cyc  = 0;
    seen = 1'b0;
    while (cyc < 400 && !seen) begin
      @(negedge clk);
      cyc++;
      if (done) seen = 1'b1;
      start = (cyc == 10);
      if (cyc == 10) begin
        nonce_start = 32'd99;
        nonce_end   = 32'd99;
      end
      hit = (cyc == 20) || (cyc == 66) || (check_en && nonce == 32'd21);
    end
    #1;
    hit = 1'b0;
    start = 1'b0;
    exp_q.push_back(32'd20); exp_q.push_back(32'd21);
    checks++;
    if (!seen || cyc != 136) begin
      errors++;
      $display("FAIL busy_latency: got cycle %0d seen=%b, expected 136", cyc, seen);
    end
    checks++;
    if (found !== 1'b1 || exhausted !== 1'b0 || nonce !== 32'd21 || load_cnt != 2) begin
      errors++;
      $display("FAIL hit_at_end: got found=%b exh=%b nonce=%h loads=%0d, expected 1 0 15 2",
               found, exhausted, nonce, load_cnt);
    end
    check_stream("busy");
  endtask

  task automatic test_start_abort_idle();
    int cyc; bit seen;
    start_job(32'd40, 32'd40, 1'b1);
    checks++;
    if (state !== LOAD || busy !== 1'b1) begin
      errors++;
      $display("FAIL start_abort_idle: got state=%0d busy=%b, expected LOAD 1", state, busy);
    end
    wait_done(400, cyc, seen);
    checks++;
    if (!seen || cyc != 68 || exhausted !== 1'b1 || nonce !== 32'd40) begin
      errors++;
      $display("FAIL start_abort_done: got cycle %0d exh=%b nonce=%h, expected 68 1 28", cyc, exhausted, nonce);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    clear_mon();
    test_reset();
    test_single_hit();
    test_range();
    test_wrap();
    test_abort();
    test_busy_ignore();
    test_start_abort_idle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
